// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcode and format constants shared by the immediate generator
package imm_gen_pkg;

    localparam int FMT_W = 3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32I/RV64I immediate decode and sign extension
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [FMT_W-1:0] fmt_o,
    output logic             illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                fmt_o = FMT_I;
            end
            OP_STORE: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                fmt_o = FMT_S;
            end
            OP_BRANCH: begin
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
                fmt_o = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {instr_i[31:12], 12'b0};
                fmt_o = FMT_U;
            end
            OP_JAL: begin
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
                fmt_o = FMT_J;
            end
            default: begin
                imm32     = '0;
                fmt_o     = FMT_NONE;
                illegal_o = 1'b1;
            end
        endcase
    end

    // bit 31 of every legal imm32 equals instr[31], so a signed widen gives the XLEN extension
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid output; IMM_GEN_ILLEGAL_CNT_EN adds illegal_cnt
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter bit ZERO_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal,
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    output logic [15:0]      illegal_cnt,
`endif
    output logic [31:0]      out_instr
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [FMT_W-1:0] fmt;
        logic             illegal;
        logic [31:0]      instr;
    } res_t;

    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    res_t            out_q, out_d, skid_q, skid_d, new_res;
    logic            out_valid_q, out_valid_d;
    logic            skid_full_q, skid_full_d;
    logic [XLEN-1:0] last_imm_q, last_imm_d;
    logic            accept, consume, out_free;

    assign accept   = in_valid && !skid_full_q;
    assign consume  = out_valid_q && out_ready;
    assign out_free = !out_valid_q || consume;

    always_comb begin
        new_res.imm     = (dec_illegal && !ZERO_ON_ILLEGAL) ? last_imm_q : dec_imm;
        new_res.fmt     = dec_fmt;
        new_res.illegal = dec_illegal;
        new_res.instr   = in_instr;
    end

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        last_imm_d  = last_imm_q;
        if (accept) begin
            last_imm_d = new_res.imm;
        end
        // A full skid blocks input, so the only move is skid into a draining OUT
        if (skid_full_q) begin
            if (consume) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                out_d       = new_res;
                out_valid_d = 1'b1;
            end else begin
                skid_d      = new_res;
                skid_full_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            last_imm_q  <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            last_imm_q  <= last_imm_d;
        end
    end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (consume && out_q.illegal && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

    assign in_ready    = !skid_full_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_instr   = out_q.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_instr;
    logic [2:0]  out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_instr64;
    logic [2:0]  out_fmt64;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt, illegal_cnt64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        .illegal_cnt (illegal_cnt),
`endif
        .out_instr   (out_instr)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (out_imm64),
        .out_fmt     (out_fmt64),
        .out_illegal (out_illegal64),
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        .illegal_cnt (illegal_cnt64),
`endif
        .out_instr   (out_instr64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        tab[12];
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          exp_cnt = 0;
    logic [6:0]  ops[8];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA bit-field rules
    function automatic vec_t ref_decode(input logic [31:0] ins);
        vec_t        r;
        logic [31:0] sgn;
        sgn     = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        r.instr = ins;
        r.ill   = 1'b0;
        r.imm   = 32'h0;
        r.fmt   = 3'd0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin r.fmt = 3'd1; r.imm = (sgn << 12) | (ins >> 20); end
            7'h23: begin
                r.fmt = 3'd2;
                r.imm = (sgn << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
            end
            7'h63: begin
                r.fmt = 3'd3;
                r.imm = (sgn << 12) | (((ins >> 7) & 32'h1) << 11)
                      | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            end
            7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                r.fmt = 3'd5;
                r.imm = (sgn << 20) | (ins & 32'h000F_F000)
                      | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            end
            default: begin r.fmt = 3'd0; r.ill = 1'b1; r.imm = 32'h0; end
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        vec_t        e;
        logic [63:0] e64;
        cmp("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() > 0});
        cmp("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < 2});
        cmp("in_ready64", {63'b0, in_ready64}, {63'b0, exp_q.size() < 2});
        if (out_valid && exp_q.size() > 0) begin
            e   = exp_q[0];
            e64 = e.ill ? 64'h0 : {{32{e.instr[31]}}, e.imm};
            cmp("out_imm", {32'b0, out_imm}, {32'b0, e.imm});
            cmp("out_fmt", {61'b0, out_fmt}, {61'b0, e.fmt});
            cmp("out_illegal", {63'b0, out_illegal}, {63'b0, e.ill});
            cmp("out_instr", {32'b0, out_instr}, {32'b0, e.instr});
            cmp("out_imm64", out_imm64, e64);
        end
`ifdef IMM_GEN_ILLEGAL_CNT_EN
        cmp("illegal_cnt", {48'b0, illegal_cnt}, 64'(exp_cnt));
`endif
    endtask

    task automatic step(input logic v, input vec_t e, input logic rdy);
        logic acc, con;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_instr  = e.instr;
        out_ready = rdy;
        acc = v && in_ready;
        con = out_valid && rdy;
        if (con && exp_q.size() > 0) begin
            if (exp_q[0].ill && exp_cnt < 16'hFFFF) exp_cnt++;
            void'(exp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(e);
            n_acc++;
        end
    endtask

    initial begin
        vec_t idle;
        vec_t r;
        int   base;
        logic [31:0] ins;

        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        idle = '{32'h0, 32'h0, 3'd0, 1'b1};
        tab[0]  = '{32'h03052283, 32'h0000_0030, 3'd1, 1'b0};
        tab[1]  = '{32'h80230293, 32'hFFFF_F802, 3'd1, 1'b0};
        tab[2]  = '{32'hFF848FE3, 32'hFFFF_FFFE, 3'd3, 1'b0};
        tab[3]  = '{32'h12345537, 32'h1234_5000, 3'd4, 1'b0};
        tab[4]  = '{32'h0080006F, 32'h0000_0008, 3'd5, 1'b0};
        tab[5]  = '{32'h0000007F, 32'h0000_0000, 3'd0, 1'b1};
        tab[6]  = '{32'h00112623, 32'h0000_000C, 3'd2, 1'b0};
        tab[7]  = '{32'hFE112E23, 32'hFFFF_FFFC, 3'd2, 1'b0};
        tab[8]  = '{32'hFFFFF097, 32'hFFFF_F000, 3'd4, 1'b0};
        tab[9]  = '{32'h000080E7, 32'h0000_0000, 3'd1, 1'b0};
        tab[10] = '{32'hFFFFFFFF, 32'h0000_0000, 3'd0, 1'b1};
        tab[11] = '{32'h800000EF, 32'hFFF0_0000, 3'd5, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst_out_valid", {63'b0, out_valid}, 64'h0);
        cmp("rst_in_ready", {63'b0, in_ready}, 64'h1);
        cmp("rst_out_imm", {32'b0, out_imm}, 64'h0);
        cmp("rst_out_fmt", {61'b0, out_fmt}, 64'h0);
        cmp("rst_out_illegal", {63'b0, out_illegal}, 64'h0);
        cmp("rst_out_instr", {32'b0, out_instr}, 64'h0);
        rst_n = 1'b1;

        // Back-to-back table vectors with the consumer always ready
        for (int i = 0; i < 12; i++) step(1'b1, tab[i], 1'b1);
        repeat (3) step(1'b0, idle, 1'b1);

        // Stall: three offered under 4 cycles of back-pressure, only two fit
        base = n_acc;
        step(1'b1, tab[1], 1'b0);
        step(1'b1, tab[2], 1'b0);
        step(1'b1, tab[3], 1'b0);
        step(1'b1, tab[3], 1'b0);
        cmp("stall_accepts", 64'(n_acc - base), 64'd2);
        step(1'b1, tab[3], 1'b1);
        step(1'b1, tab[3], 1'b1);
        step(1'b0, idle, 1'b1);
        cmp("stall_total", 64'(n_acc - base), 64'd3);
        repeat (2) step(1'b0, idle, 1'b1);

        // Illegal opcode held under back-pressure is counted once on consume
        step(1'b1, tab[5], 1'b0);
        repeat (3) step(1'b0, idle, 1'b0);
        repeat (3) step(1'b0, idle, 1'b1);

        // Reset with OUT and SKID both full
        step(1'b1, tab[3], 1'b0);
        step(1'b1, tab[4], 1'b0);
        step(1'b0, idle, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("midrst_out_valid", {63'b0, out_valid}, 64'h0);
        cmp("midrst_in_ready", {63'b0, in_ready}, 64'h1);
        cmp("midrst_out_imm", {32'b0, out_imm}, 64'h0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, idle, 1'b1);
        step(1'b1, tab[0], 1'b1);
        repeat (2) step(1'b0, idle, 1'b1);

        // Randomized traffic against the queue model
        for (int c = 0; c < 2000; c++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 7)];
            r = ref_decode(ins);
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0);
        end
        repeat (4) step(1'b0, idle, 1'b1);
        cmp("drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
